// File: rtl/clk_ratio_meter_pkg.sv
// ============================================================================
// Module      : clk_ratio_meter_pkg
// Description : Shared types and helpers for the clock ratio meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_ratio_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    // Wide enough for any CNT_W up to 32 plus one guard bit
    localparam int c_DIFF_W = 33;

    function automatic logic [c_DIFF_W-1:0] abs_diff(
        input logic [c_DIFF_W-1:0] a,
        input logic [c_DIFF_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module      : sync_edge_det
// Description : Three-flop synchronizer with rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign sync_out = r_s2;
    assign rise     = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/clk_ratio_meter.sv
// ============================================================================
// Module      : clk_ratio_meter
// Description : Measures period/high time of a slow signal in clk cycles,
//               with lock and edge-loss detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]    c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]          c_LOCK    = 4'(LOCK_COUNT);
    localparam logic [c_DIFF_W-1:0] c_TOL     = c_DIFF_W'(TOL);
    localparam int                  c_PAD     = c_DIFF_W - CNT_W;

    logic w_sync;
    logic w_rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sig_in),
        .sync_out (w_sync),
        .rise     (w_rise)
    );

    state_t           r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [CNT_W-1:0] r_hcnt,      w_hcnt_nxt;
    logic [CNT_W-1:0] r_cap_p,     w_cap_p_nxt;
    logic [CNT_W-1:0] r_cap_h,     w_cap_h_nxt;
    logic             r_pend,      w_pend_nxt;
    logic             r_have_prev, w_have_prev_nxt;
    logic [3:0]       r_match,     w_match_nxt;
    logic [CNT_W-1:0] r_period,    w_period_nxt;
    logic [CNT_W-1:0] r_high,      w_high_nxt;
    logic             r_valid,     w_valid_nxt;
    logic             r_locked,    w_locked_nxt;
    logic             r_timeout,   w_timeout_nxt;

    logic [c_DIFF_W-1:0] w_diff;
    logic [3:0]          w_match_inc;

    // r_period doubles as the previous stored period for the lock compare
    assign w_diff      = abs_diff({{c_PAD{1'b0}}, r_cap_p}, {{c_PAD{1'b0}}, r_period});
    assign w_match_inc = (r_match >= c_LOCK) ? c_LOCK : r_match + 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hcnt_nxt      = r_hcnt;
        w_cap_p_nxt     = r_cap_p;
        w_cap_h_nxt     = r_cap_h;
        w_pend_nxt      = 1'b0;
        w_have_prev_nxt = r_have_prev;
        w_match_nxt     = r_match;
        w_period_nxt    = r_period;
        w_high_nxt      = r_high;
        w_valid_nxt     = 1'b0;
        w_locked_nxt    = r_locked;
        w_timeout_nxt   = 1'b0;

        if (clear) begin
            w_state_nxt     = WAIT_FIRST;
            w_cnt_nxt       = '0;
            w_hcnt_nxt      = '0;
            w_cap_p_nxt     = '0;
            w_cap_h_nxt     = '0;
            w_have_prev_nxt = 1'b0;
            w_match_nxt     = '0;
            w_period_nxt    = '0;
            w_high_nxt      = '0;
            w_locked_nxt    = 1'b0;
        end else if (!en) begin
            w_state_nxt     = WAIT_FIRST;
            w_cnt_nxt       = '0;
            w_hcnt_nxt      = '0;
            w_have_prev_nxt = 1'b0;
            w_match_nxt     = '0;
            w_locked_nxt    = 1'b0;
        end else begin
            // Second stage of a measurement: publish and run the lock compare
            if (r_pend) begin
                w_valid_nxt     = 1'b1;
                w_period_nxt    = r_cap_p;
                w_high_nxt      = r_cap_h;
                w_have_prev_nxt = 1'b1;
                if (!r_have_prev) begin
                    w_match_nxt = '0;
                end else if (w_diff <= c_TOL) begin
                    w_match_nxt = w_match_inc;
                    if (w_match_inc == c_LOCK) begin
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = LOCKED;
                    end
                end else begin
                    w_match_nxt  = '0;
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = MEASURE;
                end
            end

            case (r_state)
                WAIT_FIRST: begin
                    if (w_rise) begin
                        w_cnt_nxt   = '0;
                        w_hcnt_nxt  = c_ONE;
                        w_state_nxt = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (w_rise) begin
                        w_cap_p_nxt = r_cnt + c_ONE;
                        w_cap_h_nxt = r_hcnt;
                        w_pend_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_hcnt_nxt  = c_ONE;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_timeout_nxt   = 1'b1;
                        w_locked_nxt    = 1'b0;
                        w_match_nxt     = '0;
                        w_have_prev_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                        w_hcnt_nxt      = '0;
                        w_state_nxt     = WAIT_FIRST;
                    end else begin
                        w_cnt_nxt  = r_cnt + c_ONE;
                        w_hcnt_nxt = r_hcnt + {{(CNT_W-1){1'b0}}, w_sync};
                    end
                end
                default: begin
                    w_state_nxt = WAIT_FIRST;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_FIRST;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_cap_p     <= '0;
            r_cap_h     <= '0;
            r_pend      <= 1'b0;
            r_have_prev <= 1'b0;
            r_match     <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_cap_p     <= w_cap_p_nxt;
            r_cap_h     <= w_cap_h_nxt;
            r_pend      <= w_pend_nxt;
            r_have_prev <= w_have_prev_nxt;
            r_match     <= w_match_nxt;
            r_period    <= w_period_nxt;
            r_high      <= w_high_nxt;
            r_valid     <= w_valid_nxt;
            r_locked    <= w_locked_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign meas_valid = r_valid;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule

`default_nettype wire
